// File: rtl/y86_seq_ctrl.sv
// ---------------------------------------------------------------------------
// y86_seq_ctrl
//   Multi-cycle sequencer for the Y86-64 core. Each instruction walks through
//   FETCH -> DECODE -> EXEC -> [MEM] -> WB -> PC. The sequencer issues one
//   datapath enable per stage, gates the condition-code latch to EXEC of OPQ,
//   runs the instruction/data memory req/ack handshakes and owns the
//   architectural status code.
//
//   Outputs are a Moore decode of the state register and the captured icode.
//
//   Optional build macro:
//     Y86_MEM_TIMEOUT_EN - a FETCH or MEM wait that lasts TIMEOUT cycles
//                          without an ack drops the request and halts with
//                          status ADR. An ack in the expiry cycle still wins.
//                          Without the macro the handshakes wait indefinitely.
//
// Parameters
//   CNT_W    width of the retired-instruction counter
//   TIMEOUT  memory-ack timeout in cycles (only with Y86_MEM_TIMEOUT_EN)
//
// Ports
//   clk_i          clock, rising edge
//   rst_i          asynchronous active-high reset
//   start_i        leave IDLE and begin fetching
//   imem_req_o     instruction fetch request (held until imem_ack_i)
//   imem_ack_i     fetch complete; icode_i/instr_valid_i/imem_err_i valid
//   imem_err_i     fetch address error
//   instr_valid_i  fetched instruction decodes legally
//   icode_i        fetched icode
//   dmem_req_o     data memory request (held until dmem_ack_i)
//   dmem_we_o      data memory write, valid with dmem_req_o
//   dmem_ack_i     data access complete
//   dmem_err_i     data address error, valid with dmem_ack_i
//   decode_en_o    latch register-file read values
//   exec_en_o      latch ALU result valE
//   cc_en_o        condition-code load enable
//   wb_en_o        register-file write enable
//   pc_en_o        PC update enable
//   retire_o       one-cycle pulse per retired instruction
//   busy_o         high in any state except IDLE and HALTED
//   stat_o         status: AOK=1 HLT=2 ADR=3 INS=4
//   instret_o      retired instruction count (wraps)
// ---------------------------------------------------------------------------
module y86_seq_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             imem_req_o,
  input  logic             imem_ack_i,
  input  logic             imem_err_i,
  input  logic             instr_valid_i,
  input  logic [3:0]       icode_i,
  output logic             dmem_req_o,
  output logic             dmem_we_o,
  input  logic             dmem_ack_i,
  input  logic             dmem_err_i,
  output logic             decode_en_o,
  output logic             exec_en_o,
  output logic             cc_en_o,
  output logic             wb_en_o,
  output logic             pc_en_o,
  output logic             retire_o,
  output logic             busy_o,
  output logic [2:0]       stat_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] ST_AOK = 3'd1;
  localparam logic [2:0] ST_HLT = 3'd2;
  localparam logic [2:0] ST_ADR = 3'd3;
  localparam logic [2:0] ST_INS = 3'd4;

  // A zero timeout would expire before any ack could be seen.
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("y86_seq_ctrl: TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_PC     = 3'd6,
    S_HALTED = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       icode_q, icode_d;
  logic [2:0]       stat_q, stat_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  logic is_mem_op;
  logic is_mem_write;

  assign is_mem_op = (icode_q == I_RMMOVQ) || (icode_q == I_MRMOVQ) ||
                     (icode_q == I_CALL)   || (icode_q == I_RET)    ||
                     (icode_q == I_PUSHQ)  || (icode_q == I_POPQ);

  assign is_mem_write = (icode_q == I_RMMOVQ) || (icode_q == I_CALL) ||
                        (icode_q == I_PUSHQ);

`ifdef Y86_MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_expired;

  // tmo_q counts completed wait cycles; the last allowed cycle is TIMEOUT-1.
  assign tmo_expired = (tmo_q == TMO_W'(TIMEOUT - 1));

  // Cleared on every entry into FETCH/MEM, counts only while staying there.
  always_comb begin
    tmo_d = '0;
    if ((state_d == state_q) && ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      icode_q   <= 4'h0;
      stat_q    <= ST_AOK;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      icode_q   <= icode_d;
      stat_q    <= stat_d;
      instret_q <= instret_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    icode_d   = icode_q;
    stat_d    = stat_q;
    instret_d = instret_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        // Address error outranks an illegal instruction on the same ack.
        if (imem_ack_i) begin
          if (imem_err_i) begin
            stat_d  = ST_ADR;
            state_d = S_HALTED;
          end else if (!instr_valid_i) begin
            stat_d  = ST_INS;
            state_d = S_HALTED;
          end else begin
            icode_d = icode_i;
            state_d = S_DECODE;
          end
        end
`ifdef Y86_MEM_TIMEOUT_EN
        else if (tmo_expired) begin
          stat_d  = ST_ADR;
          state_d = S_HALTED;
        end
`endif
      end
      S_DECODE: begin
        if (icode_q == I_HALT) begin
          stat_d  = ST_HLT;
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = is_mem_op ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ack_i) begin
          if (dmem_err_i) begin
            stat_d  = ST_ADR;
            state_d = S_HALTED;
          end else begin
            state_d = S_WB;
          end
        end
`ifdef Y86_MEM_TIMEOUT_EN
        else if (tmo_expired) begin
          stat_d  = ST_ADR;
          state_d = S_HALTED;
        end
`endif
      end
      S_WB: begin
        state_d = S_PC;
      end
      S_PC: begin
        instret_d = instret_q + 1'b1;
        state_d   = S_FETCH;
      end
      S_HALTED: begin
        state_d = S_HALTED;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output decode
  always_comb begin
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    decode_en_o = 1'b0;
    exec_en_o   = 1'b0;
    cc_en_o     = 1'b0;
    wb_en_o     = 1'b0;
    pc_en_o     = 1'b0;
    retire_o    = 1'b0;
    busy_o      = (state_q != S_IDLE) && (state_q != S_HALTED);
    stat_o      = stat_q;
    instret_o   = instret_q;
    case (state_q)
      S_FETCH:  imem_req_o  = 1'b1;
      S_DECODE: decode_en_o = 1'b1;
      S_EXEC: begin
        exec_en_o = 1'b1;
        cc_en_o   = (icode_q == I_OPQ);
      end
      S_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_mem_write;
      end
      // Non-writing instructions still get wb_en; the datapath selects RNONE.
      S_WB:     wb_en_o = 1'b1;
      S_PC: begin
        pc_en_o  = 1'b1;
        retire_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_y86_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_y86_seq_ctrl
//   Self-checking bench for y86_seq_ctrl. Directed scenarios cover reset,
//   instruction timing, memory handshakes, halting and faults; a randomized
//   scenario builds whole programs and predicts every cycle from the
//   instruction-level timing rules.
// ---------------------------------------------------------------------------
module tb_y86_seq_ctrl;

  localparam int CNT_W = 32;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic             imem_req_o;
  logic             imem_ack_i;
  logic             imem_err_i;
  logic             instr_valid_i;
  logic [3:0]       icode_i;
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic             dmem_ack_i;
  logic             dmem_err_i;
  logic             decode_en_o;
  logic             exec_en_o;
  logic             cc_en_o;
  logic             wb_en_o;
  logic             pc_en_o;
  logic             retire_o;
  logic             busy_o;
  logic [2:0]       stat_o;
  logic [CNT_W-1:0] instret_o;

  int n_checks = 0;
  int n_fail   = 0;

  y86_seq_ctrl #(.CNT_W(CNT_W), .TIMEOUT(255)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .imem_err_i(imem_err_i),
    .instr_valid_i(instr_valid_i), .icode_i(icode_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i),
    .dmem_err_i(dmem_err_i), .decode_en_o(decode_en_o), .exec_en_o(exec_en_o),
    .cc_en_o(cc_en_o), .wb_en_o(wb_en_o), .pc_en_o(pc_en_o),
    .retire_o(retire_o), .busy_o(busy_o), .stat_o(stat_o), .instret_o(instret_o)
  );

  always #5 clk_i = ~clk_i;

  // Packed view of the 1-bit outputs, MSB first.
  logic [9:0] obs;
  assign obs = {imem_req_o, dmem_req_o, dmem_we_o, decode_en_o, exec_en_o,
                cc_en_o, wb_en_o, pc_en_o, retire_o, busy_o};

  localparam bit [9:0] E_IREQ = 10'b1000000000;
  localparam bit [9:0] E_DREQ = 10'b0100000000;
  localparam bit [9:0] E_DWE  = 10'b0010000000;
  localparam bit [9:0] E_DEC  = 10'b0001000000;
  localparam bit [9:0] E_EXE  = 10'b0000100000;
  localparam bit [9:0] E_CC   = 10'b0000010000;
  localparam bit [9:0] E_WB   = 10'b0000001000;
  localparam bit [9:0] E_PC   = 10'b0000000100;
  localparam bit [9:0] E_RET  = 10'b0000000010;
  localparam bit [9:0] E_BUSY = 10'b0000000001;

  task automatic drive_idle();
    start_i = 0; imem_ack_i = 0; imem_err_i = 0; instr_valid_i = 0;
    icode_i = 0; dmem_ack_i = 0; dmem_err_i = 0;
  endtask

  // Leaves the bench just after a falling edge with the DUT in IDLE.
  task automatic do_reset();
    rst_i = 1;
    drive_idle();
    @(negedge clk_i);
    rst_i = 0;
  endtask

  // Pulses start from IDLE; returns in cycle 1 (first FETCH cycle).
  task automatic do_start();
    #1 start_i = 1;
    @(negedge clk_i);
    start_i = 0;
  endtask

  task automatic test_reset();
    rst_i = 1;
    drive_idle();
    #3;
    n_checks++;
    if (obs !== 10'b0) begin
      n_fail++; $display("FAIL reset_outputs got=%b exp=%b", obs, 10'b0);
    end
    n_checks++;
    if (stat_o !== 3'd1) begin
      n_fail++; $display("FAIL reset_stat got=%0d exp=1", stat_o);
    end
    n_checks++;
    if (instret_o !== '0) begin
      n_fail++; $display("FAIL reset_instret got=%0d exp=0", instret_o);
    end
    @(negedge clk_i);
    rst_i = 0;
    // IDLE without start must stay put.
    repeat (3) @(negedge clk_i);
    #1;
    n_checks++;
    if (busy_o !== 1'b0 || imem_req_o !== 1'b0) begin
      n_fail++; $display("FAIL idle_hold busy=%b req=%b exp=0,0", busy_o, imem_req_o);
    end
  endtask

  task automatic test_nop_opq();
    do_reset();
    do_start();
    for (int c = 1; c <= 12; c++) begin
      #1;
      n_checks++;
      if (retire_o !== ((c == 5) || (c == 10))) begin
        n_fail++; $display("FAIL nop_opq_retire cyc=%0d got=%b", c, retire_o);
      end
      n_checks++;
      if (cc_en_o !== (c == 8)) begin
        n_fail++; $display("FAIL nop_opq_cc_en cyc=%0d got=%b", c, cc_en_o);
      end
      imem_ack_i    = (c == 1) || (c == 6);
      instr_valid_i = 1;
      icode_i       = (c == 1) ? 4'h1 : 4'h6;
      @(negedge clk_i);
    end
    #1;
    n_checks++;
    if (instret_o !== 32'd2) begin
      n_fail++; $display("FAIL nop_opq_instret got=%0d exp=2", instret_o);
    end
    drive_idle();
  endtask

  task automatic test_pushq_delay();
    do_reset();
    do_start();
    for (int c = 1; c <= 10; c++) begin
      #1;
      n_checks++;
      if (dmem_req_o !== ((c >= 4) && (c <= 7)) || dmem_we_o !== ((c >= 4) && (c <= 7))) begin
        n_fail++; $display("FAIL pushq_dmem cyc=%0d req=%b we=%b", c, dmem_req_o, dmem_we_o);
      end
      n_checks++;
      if (retire_o !== (c == 9) || wb_en_o !== (c == 8)) begin
        n_fail++; $display("FAIL pushq_retire_wb cyc=%0d retire=%b wb=%b", c, retire_o, wb_en_o);
      end
      imem_ack_i    = (c == 1);
      instr_valid_i = 1;
      icode_i       = 4'hA;
      dmem_ack_i    = (c == 7);
      @(negedge clk_i);
    end
    drive_idle();
  endtask

  task automatic test_halt();
    do_reset();
    do_start();
    for (int c = 1; c <= 8; c++) begin
      #1;
      n_checks++;
      if (decode_en_o !== (c == 2) || imem_req_o !== (c == 1) || retire_o !== 1'b0) begin
        n_fail++; $display("FAIL halt_enables cyc=%0d dec=%b req=%b ret=%b", c, decode_en_o, imem_req_o, retire_o);
      end
      n_checks++;
      if (busy_o !== (c <= 2) || stat_o !== ((c >= 3) ? 3'd2 : 3'd1)) begin
        n_fail++; $display("FAIL halt_status cyc=%0d busy=%b stat=%0d", c, busy_o, stat_o);
      end
      imem_ack_i    = (c == 1);
      instr_valid_i = 1;
      icode_i       = 4'h0;
      start_i       = (c == 4) || (c == 6);
      @(negedge clk_i);
    end
    drive_idle();
  endtask

  task automatic test_faults();
    int code, halt_c;
    for (int s = 0; s < 3; s++) begin
      code   = (s == 1) ? 4 : 3;
      halt_c = (s == 2) ? 5 : 2;
      do_reset();
      do_start();
      for (int c = 1; c <= 7; c++) begin
        #1;
        n_checks++;
        if (stat_o !== ((c >= halt_c) ? 3'(code) : 3'd1) || busy_o !== (c < halt_c)) begin
          n_fail++; $display("FAIL fault_%0d_status cyc=%0d stat=%0d busy=%b exp_code=%0d", s, c, stat_o, busy_o, code);
        end
        n_checks++;
        if (wb_en_o !== 1'b0) begin
          n_fail++; $display("FAIL fault_%0d_wb cyc=%0d got=%b exp=0", s, c, wb_en_o);
        end
        imem_ack_i    = (c == 1);
        imem_err_i    = (s == 0);
        instr_valid_i = (s == 2);
        icode_i       = 4'h5;
        dmem_ack_i    = (c == 4);
        dmem_err_i    = 1;
        @(negedge clk_i);
      end
      drive_idle();
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    do_start();
    for (int c = 1; c <= 8; c++) begin
      #1;
      imem_ack_i    = (c == 1) || (c == 6);
      instr_valid_i = 1;
      icode_i       = (c == 1) ? 4'h1 : 4'hA;
      @(negedge clk_i);
    end
    drive_idle();
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b1 || instret_o !== 32'd1) begin
      n_fail++; $display("FAIL midmem_before req=%b instret=%0d exp=1,1", dmem_req_o, instret_o);
    end
    #2 rst_i = 1;
    #1;
    n_checks++;
    if (dmem_req_o !== 1'b0 || busy_o !== 1'b0 || stat_o !== 3'd1 || instret_o !== '0) begin
      n_fail++; $display("FAIL midmem_reset req=%b busy=%b stat=%0d instret=%0d exp=0,0,1,0",
                         dmem_req_o, busy_o, stat_o, instret_o);
    end
    @(negedge clk_i);
    rst_i = 0;
  endtask

  // ---------------- randomized programs vs instruction-level model --------
  typedef struct {
    bit          start, iack, ierr, ivld, dack, derr;
    bit [3:0]    icode;
    bit [9:0]    exp;
    bit [2:0]    stat;
    int unsigned ret;
  } cyc_t;

  cyc_t        sched[$];
  bit [2:0]    mdl_stat;
  int unsigned mdl_ret;

  // Random inputs for one cycle; acks are suppressed where the handshake
  // under test is waiting, everything else is noise the DUT must ignore.
  function automatic cyc_t mk(bit [9:0] exp, bit fetch_wait, bit mem_wait);
    cyc_t c;
    c.start = 1'($urandom);
    c.iack  = fetch_wait ? 1'b0 : 1'($urandom);
    c.ierr  = 1'($urandom);
    c.ivld  = 1'($urandom);
    c.icode = 4'($urandom);
    c.dack  = mem_wait ? 1'b0 : 1'($urandom);
    c.derr  = 1'($urandom);
    c.exp   = exp;
    c.stat  = mdl_stat;
    c.ret   = mdl_ret;
    return c;
  endfunction

  function automatic void halt_tail(bit [2:0] code);
    mdl_stat = code;
    repeat (4) sched.push_back(mk(10'b0, 1'b0, 1'b0));
  endfunction

  function automatic void gen_program(int n);
    cyc_t     c;
    bit [3:0] ic;
    int       fault, w;
    bit       memop, wr;
    mdl_stat = 3'd1;
    mdl_ret  = 0;
    c = mk(10'b0, 1'b0, 1'b0);
    c.start = 1'b1;
    sched.push_back(c);
    for (int k = 0; k < n; k++) begin
      ic    = (k == n - 1) ? 4'h0 : 4'($urandom_range(1, 11));
      fault = $urandom_range(0, 15);
      w     = $urandom_range(0, 3);
      repeat (w) sched.push_back(mk(E_IREQ | E_BUSY, 1'b1, 1'b0));
      c = mk(E_IREQ | E_BUSY, 1'b1, 1'b0);
      c.iack  = 1'b1;
      c.icode = ic;
      c.ierr  = (fault == 0);
      c.ivld  = (fault == 0) ? 1'($urandom) : (fault != 1);
      sched.push_back(c);
      if (fault == 0) begin halt_tail(3'd3); return; end
      if (fault == 1) begin halt_tail(3'd4); return; end
      sched.push_back(mk(E_DEC | E_BUSY, 1'b0, 1'b0));
      if (ic == 4'h0) begin halt_tail(3'd2); return; end
      sched.push_back(mk(E_EXE | E_BUSY | ((ic == 4'h6) ? E_CC : 10'b0), 1'b0, 1'b0));
      memop = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) || (ic == 4'h9) ||
              (ic == 4'hA) || (ic == 4'hB);
      wr    = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
      if (memop) begin
        w = $urandom_range(0, 3);
        repeat (w) sched.push_back(mk(E_DREQ | (wr ? E_DWE : 10'b0) | E_BUSY, 1'b0, 1'b1));
        c = mk(E_DREQ | (wr ? E_DWE : 10'b0) | E_BUSY, 1'b0, 1'b1);
        c.dack = 1'b1;
        c.derr = (fault == 2);
        sched.push_back(c);
        if (fault == 2) begin halt_tail(3'd3); return; end
      end
      sched.push_back(mk(E_WB | E_BUSY, 1'b0, 1'b0));
      sched.push_back(mk(E_PC | E_RET | E_BUSY, 1'b0, 1'b0));
      mdl_ret++;
    end
  endfunction

  task automatic test_random();
    cyc_t c;
    for (int p = 0; p < 8; p++) begin
      sched.delete();
      gen_program($urandom_range(2, 12));
      do_reset();
      for (int i = 0; i < sched.size(); i++) begin
        c = sched[i];
        #1;
        n_checks++;
        if (obs !== c.exp) begin
          n_fail++; $display("FAIL rand_outputs prog=%0d idx=%0d got=%b exp=%b", p, i, obs, c.exp);
        end
        n_checks++;
        if (stat_o !== c.stat || instret_o !== CNT_W'(c.ret)) begin
          n_fail++; $display("FAIL rand_stat_instret prog=%0d idx=%0d stat=%0d/%0d instret=%0d/%0d",
                             p, i, stat_o, c.stat, instret_o, c.ret);
        end
        start_i       = c.start;
        imem_ack_i    = c.iack;
        imem_err_i    = c.ierr;
        instr_valid_i = c.ivld;
        icode_i       = c.icode;
        dmem_ack_i    = c.dack;
        dmem_err_i    = c.derr;
        @(negedge clk_i);
      end
      drive_idle();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nop_opq();
    test_pushq_delay();
    test_halt();
    test_faults();
    test_reset_mid_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
